// File: rtl/nn_ctrl_pkg.sv
// Shared types and constants for the inference sequencer.
package nn_ctrl_pkg;

  localparam int DEF_AWIDTH = 4;
  localparam int DEF_DWIDTH = 256;
  localparam int TMR_W      = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_WAIT,
    S_MAC,
    S_ACT,
    S_ACT_WAIT,
    S_CAPT,
    S_DONE
  } state_t;

  // Cycles spent on one layer: RD_ADDR, MAC, ACT, CAPT plus both waits.
  function automatic int layer_cycles(input int rd_lat, input int act_lat);
    return 4 + rd_lat + act_lat;
  endfunction

endpackage

// File: rtl/nn_wait_timer.sv
// Loadable down-counter; expires when the count reaches zero and holds there.
module nn_wait_timer
  import nn_ctrl_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_expire
);

  logic [W-1:0] r_cnt;

  // Load takes priority; otherwise count down and stop at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/nn_infer_sequencer.sv
// Sequences one feed-forward inference over the shared weight RAM and
// arbitrates that RAM port with the host weight loader.
//
// state      | meaning
// -----------+-------------------------------------------------------
// S_IDLE     | waiting for start; host writes granted here only
// S_RD_ADDR  | present layer address to RAM, load operands
// S_RD_WAIT  | hold address for RD_LAT cycles
// S_MAC      | capture dot products from the RAM word
// S_ACT      | launch activation
// S_ACT_WAIT | wait ACT_LAT cycles for activation result
// S_CAPT     | capture activation outputs, advance or finish
// S_DONE     | one-cycle completion pulse
module nn_infer_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int AWIDTH     = DEF_AWIDTH,
  parameter int DWIDTH     = DEF_DWIDTH,
  parameter int NUM_LAYERS = 2,
  parameter int RD_LAT     = 1,
  parameter int ACT_LAT    = 1,
  localparam int LW        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_done,
  output logic [LW-1:0]     o_layer_idx,
  output logic              o_load_x,
  output logic              o_mac_en,
  output logic              o_act_en,
  output logic              o_act_cap,
  output logic [AWIDTH-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DWIDTH-1:0] o_mem_wdata,
  input  logic              i_host_wr_req,
  input  logic [AWIDTH-1:0] i_host_wr_addr,
  input  logic [DWIDTH-1:0] i_host_wr_data,
  output logic              o_host_wr_gnt
);

  state_t           r_state;
  state_t           w_next;
  logic [LW-1:0]    r_layer_idx;
  logic [LW-1:0]    w_layer_next;
  logic             r_start_pend;
  logic             w_pend_next;
  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_val;
  logic             w_tmr_expire;

  nn_wait_timer #(.W(TMR_W)) u_wait_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_expire   (w_tmr_expire)
  );

  // State, layer index and pending-start registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_layer_idx  <= '0;
      r_start_pend <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_layer_idx  <= w_layer_next;
      r_start_pend <= w_pend_next;
    end
  end

  // Next-state, RAM port mux and strobe generation.
  always_comb begin
    w_next        = r_state;
    w_layer_next  = r_layer_idx;
    w_pend_next   = r_start_pend;
    w_tmr_load    = 1'b0;
    w_tmr_val     = '0;
    o_load_x      = 1'b0;
    o_mac_en      = 1'b0;
    o_act_en      = 1'b0;
    o_act_cap     = 1'b0;
    o_done        = 1'b0;
    o_mem_addr    = '0;
    o_mem_we      = 1'b0;
    o_mem_wdata   = '0;
    o_host_wr_gnt = 1'b0;

    // The inference keeps its layer address on the port for the whole layer.
    if (r_state != S_IDLE) begin
      o_mem_addr = AWIDTH'(r_layer_idx);
    end

    case (r_state)
      S_IDLE: begin
        w_layer_next = '0;
        if (i_host_wr_req) begin
          o_mem_we      = 1'b1;
          o_mem_addr    = i_host_wr_addr;
          o_mem_wdata   = i_host_wr_data;
          o_host_wr_gnt = 1'b1;
          if (i_abort) begin
            w_pend_next = 1'b0;
          end else if (i_start) begin
            w_pend_next = 1'b1;
          end
        end else if (i_abort) begin
          w_pend_next = 1'b0;
        end else if (i_start || r_start_pend) begin
          w_next      = S_RD_ADDR;
          w_pend_next = 1'b0;
        end
      end
      S_RD_ADDR: begin
        o_load_x   = 1'b1;
        w_tmr_load = 1'b1;
        w_tmr_val  = TMR_W'(RD_LAT - 1);
        w_next     = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (w_tmr_expire) begin
          w_next = S_MAC;
        end
      end
      S_MAC: begin
        o_mac_en = 1'b1;
        w_next   = S_ACT;
      end
      S_ACT: begin
        o_act_en   = 1'b1;
        w_tmr_load = 1'b1;
        w_tmr_val  = TMR_W'(ACT_LAT - 1);
        w_next     = S_ACT_WAIT;
      end
      S_ACT_WAIT: begin
        if (w_tmr_expire) begin
          w_next = S_CAPT;
        end
      end
      S_CAPT: begin
        o_act_cap = 1'b1;
        if (r_layer_idx == LW'(NUM_LAYERS - 1)) begin
          w_next = S_DONE;
        end else begin
          w_layer_next = r_layer_idx + LW'(1);
          w_next       = S_RD_ADDR;
        end
      end
      S_DONE: begin
        o_done       = 1'b1;
        w_layer_next = '0;
        w_next       = S_IDLE;
      end
      default: begin
        w_next       = S_IDLE;
        w_layer_next = '0;
      end
    endcase

    // Abort cancels a running inference without any strobe in that cycle.
    if (i_abort && (r_state != S_IDLE)) begin
      w_next       = S_IDLE;
      w_layer_next = '0;
      w_tmr_load   = 1'b0;
      o_load_x     = 1'b0;
      o_mac_en     = 1'b0;
      o_act_en     = 1'b0;
      o_act_cap    = 1'b0;
      o_done       = 1'b0;
    end
  end

  assign o_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_layer_idx = r_layer_idx;

endmodule

// File: tb/tb_nn_infer_sequencer.sv
// Directed bench for nn_infer_sequencer: default build plus an RD_LAT=3/ACT_LAT=2 build.
module tb_nn_infer_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, abort, host_req;
  logic [3:0]   host_addr;
  logic [255:0] host_data;

  logic         busy, done, load_x, mac_en, act_en, act_cap, mem_we, gnt;
  logic [0:0]   layer_idx;
  logic [3:0]   mem_addr;
  logic [255:0] mem_wdata;

  logic         start2;
  logic         zero1 = 1'b0;
  logic [3:0]   zero4 = '0;
  logic [255:0] zero256 = '0;
  logic         busy2, done2, load_x2, mac_en2, act_en2, act_cap2, mem_we2, gnt2;
  logic [0:0]   layer_idx2;
  logic [3:0]   mem_addr2;
  logic [255:0] mem_wdata2;

  int checks = 0;
  int failures = 0;

  logic [255:0] ram [16];

  wire [5:0] w_strb = {load_x, mac_en, act_en, act_cap, done, gnt};

  nn_infer_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .o_busy(busy), .o_done(done), .o_layer_idx(layer_idx),
    .o_load_x(load_x), .o_mac_en(mac_en), .o_act_en(act_en), .o_act_cap(act_cap),
    .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
    .i_host_wr_req(host_req), .i_host_wr_addr(host_addr), .i_host_wr_data(host_data),
    .o_host_wr_gnt(gnt)
  );

  nn_infer_sequencer #(.RD_LAT(3), .ACT_LAT(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_abort(zero1),
    .o_busy(busy2), .o_done(done2), .o_layer_idx(layer_idx2),
    .o_load_x(load_x2), .o_mac_en(mac_en2), .o_act_en(act_en2), .o_act_cap(act_cap2),
    .o_mem_addr(mem_addr2), .o_mem_we(mem_we2), .o_mem_wdata(mem_wdata2),
    .i_host_wr_req(zero1), .i_host_wr_addr(zero4), .i_host_wr_data(zero256),
    .o_host_wr_gnt(gnt2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected {load_x, mac_en, act_en, act_cap, done, gnt} t cycles after start acceptance.
  function automatic logic [5:0] exp_strb(input int t);
    case (t)
      1, 7:   return 6'b100000;
      3, 9:   return 6'b010000;
      4, 10:  return 6'b001000;
      6, 12:  return 6'b000100;
      13:     return 6'b000010;
      default: return 6'b000000;
    endcase
  endfunction

  task automatic run_nominal(input string tag, input bit with_host, input bit with_start);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t <= 13; t++) begin
      chk($sformatf("%s_strb_t%0d", tag, t), 256'(w_strb), 256'(exp_strb(t)));
      chk($sformatf("%s_busy_t%0d", tag, t), 256'(busy), 256'(t <= 12));
      chk($sformatf("%s_we_t%0d", tag, t), 256'(mem_we), 256'(0));
      if (t <= 12)
        chk($sformatf("%s_layer_t%0d", tag, t), 256'(layer_idx), 256'(t > 6));
      if (t == 1) chk($sformatf("%s_addr_l0", tag), 256'(mem_addr), 256'(0));
      if (t == 7) chk($sformatf("%s_addr_l1", tag), 256'(mem_addr), 256'(1));
      if (with_host && t == 2) begin
        host_req  = 1'b1;
        host_addr = 4'd2;
        host_data = {32{8'hA5}};
      end
      if (with_start && t == 3) start = 1'b1;
      if (with_start && t == 4) start = 1'b0;
      tick();
    end
  endtask

  initial begin
    int done_t, mac_a, mac_b, busy_cnt;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; host_req = 1'b0;
    host_addr = '0; host_data = '0; start2 = 1'b0;
    #12;
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_strb", 256'(w_strb), 256'(0));
    chk("rst_addr", 256'(mem_addr), 256'(0));
    chk("rst_wdata", mem_wdata, 256'(0));
    chk("rst_layer", 256'(layer_idx), 256'(0));
    rst_n = 1'b1;
    tick();

    // Reset asserted in the middle of an inference.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("mid_busy_pre", 256'(busy), 256'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 256'(busy), 256'(0));
    chk("mid_rst_strb", 256'(w_strb), 256'(0));
    chk("mid_rst_we", 256'(mem_we), 256'(0));
    chk("mid_rst_addr", 256'(mem_addr), 256'(0));
    tick();
    rst_n = 1'b1;
    tick();
    chk("rel_busy", 256'(busy), 256'(0));
    chk("rel_layer", 256'(layer_idx), 256'(0));

    run_nominal("nom", 1'b0, 1'b0);
    chk("nom_idle", 256'(busy), 256'(0));

    // Host request raised while busy plus an ignored start.
    run_nominal("hb", 1'b1, 1'b1);
    chk("hb_gnt", 256'(gnt), 256'(1));
    chk("hb_we", 256'(mem_we), 256'(1));
    chk("hb_addr", 256'(mem_addr), 256'(2));
    chk("hb_wdata", mem_wdata, {32{8'hA5}});
    tick();
    host_req = 1'b0;
    #1;
    chk("hb_readback", ram[2], {32{8'hA5}});
    chk("hb_gnt_once", 256'(gnt), 256'(0));
    chk("hb_no_queue", 256'(busy), 256'(0));
    tick();
    chk("hb_no_queue2", 256'(busy), 256'(0));

    // Simultaneous start and host write in IDLE.
    start = 1'b1; host_req = 1'b1; host_addr = 4'd3; host_data = {16{16'h3C5A}};
    #1;
    chk("sim_strb", 256'(w_strb), 256'(6'b000001));
    chk("sim_addr", 256'(mem_addr), 256'(3));
    chk("sim_busy", 256'(busy), 256'(0));
    tick();
    start = 1'b0; host_req = 1'b0;
    #1;
    chk("sim_readback", ram[3], {16{16'h3C5A}});
    chk("sim_pend_idle", 256'(busy), 256'(0));
    tick();
    chk("sim_loadx", 256'(w_strb), 256'(6'b100000));
    chk("sim_addr0", 256'(mem_addr), 256'(0));
    chk("sim_busy1", 256'(busy), 256'(1));
    repeat (12) tick();
    chk("sim_done", 256'(w_strb), 256'(6'b000010));
    tick();

    // Abort in IDLE swallows a simultaneous start.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("idle_abort_busy", 256'(busy), 256'(0));
    tick();
    chk("idle_abort_busy2", 256'(busy), 256'(0));

    // Abort in IDLE clears a pending start.
    start = 1'b1; host_req = 1'b1; host_addr = 4'd4; host_data = '1;
    tick();
    start = 1'b0; host_req = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("pend_clr_busy", 256'(busy), 256'(0));
    tick();
    chk("pend_clr_busy2", 256'(busy), 256'(0));

    // Abort in layer 1 ACT.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("ab_at_act", 256'(w_strb), 256'(6'b001000));
    abort = 1'b1;
    #1;
    chk("ab_suppress", 256'(w_strb), 256'(0));
    tick();
    abort = 1'b0;
    chk("ab_busy", 256'(busy), 256'(0));
    chk("ab_layer", 256'(layer_idx), 256'(0));
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ab_nodone_%0d", i), 256'(w_strb), 256'(0));
      tick();
    end
    run_nominal("post_ab", 1'b0, 1'b0);

    // Longer-latency build: 9 cycles per layer.
    done_t = -1; mac_a = -1; mac_b = -1; busy_cnt = 0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      if (busy2) busy_cnt++;
      if (done2 && done_t < 0) done_t = t;
      if (mac_en2) begin
        if (mac_a < 0) mac_a = t;
        else if (mac_b < 0) mac_b = t;
      end
      tick();
    end
    chk("lat_done_t", 256'(done_t), 256'(19));
    chk("lat_mac0_t", 256'(mac_a), 256'(5));
    chk("lat_mac1_t", 256'(mac_b), 256'(14));
    chk("lat_busy_cnt", 256'(busy_cnt), 256'(18));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nn_infer_sequencer.md
Name: nn_infer_sequencer

Overview:
- Control block that sequences one feed-forward inference through the shared 256-bit weight RAM, the layer dot-product stage and the activation units.
- Issues one weight-row read per layer, then strobes operand load, MAC capture, activation launch and activation capture in fixed order.
- Arbitrates the single RAM port between inference reads and a host weight-write port; host writes are granted only while idle.
- Sits between the top level (start/done handshake, host loader) and the FeedForwardNN datapath/RAM.

Parameters:
- AWIDTH, 4, RAM address width.
- DWIDTH, 256, RAM word width (one layer's weights per word).
- NUM_LAYERS, 2, layers per inference; layer L weights live at address L.
- RD_LAT, 1, RAM read latency in cycles (>=1).
- ACT_LAT, 1, activation latency in cycles (>=1).

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RST  in  1  asynchronous, active-low reset.
- start  in  1  request an inference; sampled only in IDLE.
- abort  in  1  synchronous cancel of a running inference.
- busy  out  1  inference in progress.
- done  out  1  one-cycle pulse when an inference completes.
- layer_idx  out  $clog2(NUM_LAYERS)  layer currently being processed.
- load_x  out  1  datapath latches x inputs (first layer) or previous v outputs (later layers).
- mac_en  out  1  datapath captures the dot products from the current RAM word.
- act_en  out  1  datapath drives z into the activation inputs.
- act_cap  out  1  datapath captures the activation outputs.
- mem_addr  out  AWIDTH  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DWIDTH  RAM write data.
- host_wr_req  in  1  host write request; held until granted.
- host_wr_addr  in  AWIDTH  host write address.
- host_wr_data  in  DWIDTH  host write data.
- host_wr_gnt  out  1  one-cycle pulse; write performed in this cycle.

Behaviour:
- Reset (RST=0, asynchronous): state goes to IDLE and the start-pending flag clears. All outputs are 0, including mem_addr, mem_wdata and layer_idx.
- States: IDLE, RD_ADDR, RD_WAIT, MAC, ACT, ACT_WAIT, CAPT, DONE.
- IDLE, host write has priority:
  - If host_wr_req=1: mem_we=1, mem_addr=host_wr_addr, mem_wdata=host_wr_data and host_wr_gnt=1, all combinationally in the same cycle.
  - A start seen in that cycle sets start_pend.
- IDLE, start: if no host request, start|start_pend moves to RD_ADDR with layer_idx=0 and clears start_pend.
- RD_ADDR:
  - mem_addr=layer_idx, mem_we=0, load_x=1.
  - busy is 1 from this state through CAPT.
- RD_WAIT: hold mem_addr for RD_LAT cycles, counted by the wait counter.
- MAC (1 cycle): mac_en=1.
- ACT (1 cycle): act_en=1.
- ACT_WAIT: ACT_LAT cycles.
- CAPT (1 cycle): act_cap=1.
  - If layer_idx==NUM_LAYERS-1, go to DONE.
  - Otherwise increment layer_idx and go to RD_ADDR.
- DONE (1 cycle): done=1, busy=0, then go to IDLE and reset layer_idx to 0.
- Latency:
  - Each layer takes 4+RD_LAT+ACT_LAT cycles.
  - With defaults, start is accepted at edge k and busy is high for cycles k+1..k+12.
  - done is high in cycle k+13.
- Strobes (load_x, mac_en, act_en, act_cap, done, host_wr_gnt) are single-cycle and mutually exclusive.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; done is not pulsed and layer_idx resets.
  - Strobes are suppressed in the abort cycle.
- abort=1 in IDLE clears start_pend. A simultaneous start is ignored.
- start while busy is ignored and not queued.
- Host request while busy: host_wr_gnt stays 0 and the request is serviced in the first IDLE cycle.
- Wait counter wraps cleanly between uses and reloads on every state entry.

Decomposition:
- Package nn_ctrl_pkg holds:
  - state enum;
  - default DWIDTH/AWIDTH constants;
  - per-layer cycle-count constant (4+RD_LAT+ACT_LAT expression helper).
- One sub-module, nn_wait_timer: loadable down-counter with load value, load strobe and expire output. It is instantiated once and shared by RD_WAIT and ACT_WAIT.

Test Plan:
- Reset/idle: RST low mid-run at cycle 5 -> all outputs 0 immediately; after release, busy=0, layer_idx=0.
- Nominal inference: start pulse at edge k -> mem_addr=0 at k+1 and mem_addr=1 at k+7; mac_en at k+3 and k+9; act_cap at k+6 and k+12; done only at k+13.
- Host arbitration: host_wr_req with addr=2, data=256'hA5… while busy -> gnt=0 until IDLE. Then a single gnt pulse with mem_we=1, mem_addr=2, and a readback of address 2 matches.
- Simultaneous start + host_wr_req in IDLE -> write granted first; inference begins the next cycle (mem_addr=0, load_x=1); the start is not lost.
- Abort at layer 1 ACT -> next cycle IDLE, busy=0, no done pulse; a new start then runs the full 12-cycle sequence.
- RD_LAT=3, ACT_LAT=2 build -> per-layer cycle count 9; done at k+19.
